fifo_rr_arbiter: RTL



---
 rtl/fifo_rr_arbiter_pkg.sv | 16 +
 rtl/fifo_rr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_rr_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin FIFO drain stage.
package fifo_rr_arbiter_pkg;

  // Drain FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Width of a source index for n sources (at least one bit).
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin priority search: first eligible index after ptr, wrapping to 0.
// The current pointer itself is searched last, so a lone eligible source is
// always found again.
module fifo_rr_arbiter_rr_pick #(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = 2
) (
  input  logic [NUM_IN-1:0] eligible,
  input  logic [SRC_W-1:0]  ptr,
  output logic [SRC_W-1:0]  grant_idx,
  output logic              grant_valid
);

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path that
    // finds no eligible source would leave it unassigned and infer a latch.
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (eligible[(int'(ptr) + k) % NUM_IN]) begin
        grant_idx   = SRC_W'((int'(ptr) + k) % NUM_IN);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains NUM_IN upstream FIFOs in weighted round-robin order into one
// downstream FIFO, tagging each forwarded word with its source index.
// Pop in cycle N, write in cycle N+1; one word per cycle sustained.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 2,
  parameter int SRC_W      = src_width(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            buf_empty_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] buf_out_in,
  output logic [NUM_IN-1:0]            rd_en_out,
  input  logic                         almost_full_down,
  input  logic                         buf_full_down,
  output logic                         wr_en_down,
  output logic [DATA_WIDTH-1:0]        data_down,
  output logic [SRC_W-1:0]             src_id,
  output logic                         active
);

  state_t            state;
  logic [SRC_W-1:0]  ptr;
  logic [3:0]        burst_cnt;
  logic              cur_valid;   // ptr names a source that has actually been popped

  logic [NUM_IN-1:0] eligible;
  logic              any_elig;
  logic              throttle;
  logic              keep;
  logic              pick_valid;
  logic [SRC_W-1:0]  pick_idx;
  logic [SRC_W-1:0]  grant_sel;
  logic              grant_ok;
  logic              pop;

  assign eligible = ~buf_empty_in;
  assign any_elig = |eligible;
  assign throttle = almost_full_down | buf_full_down;

  // Stay on the current source until it empties or its burst allowance is used.
  assign keep      = cur_valid && eligible[ptr] && (burst_cnt < 4'(MAX_BURST - 1));
  assign grant_sel = keep ? ptr : pick_idx;
  assign grant_ok  = keep | pick_valid;
  assign pop       = (state == ST_RUN) && !throttle && grant_ok;
  assign active    = (state == ST_RUN);

  fifo_rr_arbiter_rr_pick #(
    .NUM_IN (NUM_IN),
    .SRC_W  (SRC_W)
  ) u_rr_pick (
    .eligible    (eligible),
    .ptr         (ptr),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // One-hot pop strobe to the granted upstream FIFO.
  always_comb begin
    rd_en_out = '0;
    if (pop) rd_en_out[grant_sel] = 1'b1;
  end

  // Word popped last cycle is on its FIFO's buf_out now; select it by src_id.
  always_comb begin
    data_down = '0;
    if (wr_en_down) data_down = buf_out_in[src_id*DATA_WIDTH +: DATA_WIDTH];
  end

  // FSM, grant pointer/burst bookkeeping and the registered write strobe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      burst_cnt  <= '0;
      cur_valid  <= 1'b0;
      wr_en_down <= 1'b0;
      src_id     <= '0;
    end else begin
      wr_en_down <= pop;
      if (pop) begin
        src_id    <= grant_sel;
        cur_valid <= 1'b1;
        if (keep) begin
          burst_cnt <= burst_cnt + 4'd1;
        end else begin
          ptr       <= grant_sel;
          burst_cnt <= '0;
        end
      end

      case (state)
        ST_IDLE:  if (any_elig) state <= throttle ? ST_STALL : ST_RUN;
        ST_RUN: begin
          if (throttle)      state <= ST_STALL;
          else if (!any_elig) state <= ST_IDLE;
        end
        ST_STALL: if (!throttle) state <= any_elig ? ST_RUN : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
